// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with runtime prescaler and double-buffered per-channel duty.
// New duty values wait in a shadow register and reach the comparators only at the period wrap.
module pwm_multi_channel #(
    parameter  int CHANNELS = 16,
    parameter  int WIDTH    = 8,
    parameter  int PRESC_W  = 12,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                wr_valid,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] out_en,
    input  logic [CHANNELS-1:0] pwm_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    // Counter runs 0..MAX-1 with MAX = 2^WIDTH-1, so an all-ones duty never sees cnt >= duty.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

    logic [PRESC_W-1:0]  psc_q, psc_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q;
    logic                tick;
    logic                wrap;
    logic                wr_hit;

    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] active_q [CHANNELS];

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        tick   = (psc_q >= prescale);
        psc_d  = tick ? '0 : psc_q + 1'b1;
        wrap   = tick && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        wr_hit = wr_valid && (32'(wr_chan) < CHANNELS);
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = out_en[i] & (~pwm_en[i] | (cnt_q < active_q[i]));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q          <= '0;
            cnt_q          <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            psc_q          <= psc_d;
            cnt_q          <= cnt_d;
            pwm_q          <= pwm_d;
            period_start_q <= wrap;
        end
    end

    // NOTE: the duty arrays are reset on purpose: after reset the outputs must stay low until a fresh write is committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_hit) begin
                shadow_q[wr_chan] <= wr_duty;
            end
            // A write on the commit edge lands in shadow only; active takes the pre-write value.
            if (wrap) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: a 4-channel/8-bit instance for the main behaviour
// and a 5-channel/4-bit instance where an out-of-range channel index is representable.
module tb_pwm_multi_channel;

    localparam int CH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [11:0]   prescale;
    logic          wr_valid;
    logic [1:0]    wr_chan;
    logic [7:0]    wr_duty;
    logic [CH-1:0] out_en, pwm_en, pwm_out;
    logic          period_start;

    logic [3:0]    prescale5;
    logic          wr_valid5;
    logic [2:0]    wr_chan5;
    logic [3:0]    wr_duty5;
    logic [4:0]    out_en5, pwm_en5, pwm_out5;
    logic          period_start5;

    pwm_multi_channel #(.CHANNELS(4), .WIDTH(8), .PRESC_W(12)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .prescale     (prescale),
        .wr_valid     (wr_valid),
        .wr_chan      (wr_chan),
        .wr_duty      (wr_duty),
        .out_en       (out_en),
        .pwm_en       (pwm_en),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    pwm_multi_channel #(.CHANNELS(5), .WIDTH(4), .PRESC_W(4)) u_dut5 (
        .clk          (clk),
        .rst          (rst),
        .prescale     (prescale5),
        .wr_valid     (wr_valid5),
        .wr_chan      (wr_chan5),
        .wr_duty      (wr_duty5),
        .out_en       (out_en5),
        .pwm_en       (pwm_en5),
        .pwm_out      (pwm_out5),
        .period_start (period_start5)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int period_len;
    int hi [CH];
    int hi5 [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        wr_chan  = ch;
        wr_duty  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Advances to the next negedge sample showing period_start; returns samples waited.
    task automatic wait_ps(input int budget, output int waited);
        waited = 0;
        while (period_start !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("ps_wait_budget", 32'(waited < budget), 1);
    endtask

    // Starts on a period_start sample; counts samples and per-channel highs up to the next one.
    // Optionally raises wr_valid during sample index wr_at (write lands on the following edge).
    task automatic measure(input int wr_at, input logic [1:0] ch, input logic [7:0] d);
        period_len = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
        wr_chan = ch;
        wr_duty = d;
        do begin
            for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
            wr_valid = (period_len == wr_at);
            period_len++;
            @(negedge clk);
        end while (period_start !== 1'b1 && period_len < 5000);
        wr_valid = 1'b0;
        check("measure_budget", 32'(period_len < 5000), 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int lowbad;

        rst       = 1'b1;
        prescale  = '0;
        wr_valid  = 1'b0;
        wr_chan   = '0;
        wr_duty   = '0;
        out_en    = 4'hF;
        pwm_en    = 4'hF;
        prescale5 = '0;
        wr_valid5 = 1'b0;
        wr_chan5  = '0;
        wr_duty5  = '0;
        out_en5   = 5'h1F;
        pwm_en5   = 5'h1F;

        repeat (3) @(negedge clk);
        check("reset_pwm_out", pwm_out, 0);
        check("reset_period_start", period_start, 0);

        // 1: ch0=128 at prescale 0; first commit 255 clks after release, no pulse out of reset.
        rst = 1'b0;
        wr(2'd0, 8'd128);
        wait_ps(600, w);
        check("first_ps_latency", w + 1, 255);
        measure(-1, 2'd0, 8'd0);
        check("t1_period_len", period_len, 255);
        check("t1_ch0_high", hi[0], 128);
        check("t1_ch1_high", hi[1], 0);
        check("t1_ch2_high", hi[2], 0);
        check("t1_ch3_high", hi[3], 0);

        // 2: ch1=0, ch2=255; check 3 full periods after the first committed one.
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd255);
        wait_ps(600, w);
        measure(-1, 2'd0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            measure(-1, 2'd0, 8'd0);
            check("t2_ch1_never_high", hi[1], 0);
            check("t2_ch2_always_high", hi[2], 255);
            check("t2_ch0_still_128", hi[0], 128);
        end
        pwm_en[3] = 1'b0;
        @(negedge clk);
        check("t2_ch3_static_high", pwm_out[3], 1);
        out_en[3] = 1'b0;
        @(negedge clk);
        check("t2_ch3_disabled_low", pwm_out[3], 0);
        out_en[3] = 1'b1;
        pwm_en[3] = 1'b1;

        // 3: prescale 3 -> 1020-clk period, 64 ticks = 256 clks high on ch0, 1 tick = 4 clks on ch1.
        prescale = 12'd3;
        wr(2'd0, 8'd64);
        wr(2'd1, 8'd1);
        wait_ps(3000, w);
        measure(-1, 2'd0, 8'd0);
        check("t3_period_len", period_len, 1020);
        check("t3_ch0_high", hi[0], 256);
        check("t3_ch1_high", hi[1], 4);
        check("t3_ch2_high", hi[2], 1020);
        check("t3_ch3_high", hi[3], 0);
        // psc is 0 on the period_start sample; two edges later it is 2, then drop prescale.
        @(negedge clk);
        @(negedge clk);
        prescale = 12'd0;
        @(negedge clk);
        check("t3_psc_drop_ch1_before", pwm_out[1], 1);
        @(negedge clk);
        check("t3_psc_drop_ch1_after", pwm_out[1], 0);
        check("t3_psc_drop_ch0", pwm_out[0], 1);

        // 4: double buffering of ch0 duty.
        wr(2'd0, 8'd50);
        wait_ps(600, w);
        measure(100, 2'd0, 8'd200);
        check("t4_mid_write_keeps_old", hi[0], 50);
        check("t4_period_len", period_len, 255);
        measure(254, 2'd0, 8'd50);
        check("t4_new_duty_applied", hi[0], 200);
        measure(-1, 2'd0, 8'd0);
        check("t4_commit_cycle_write_old", hi[0], 200);
        measure(-1, 2'd0, 8'd0);
        check("t4_commit_cycle_write_new", hi[0], 50);

        // 5: asynchronous reset mid-period with outputs high.
        repeat (10) @(negedge clk);
        check("t5_pre_reset_outputs", pwm_out, 4'b0101);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_reset_pwm", pwm_out, 0);
        check("t5_async_reset_ps", period_start, 0);
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        lowbad = 0;
        while (period_start !== 1'b1 && w < 600) begin
            if (pwm_out !== 4'h0) lowbad++;
            @(negedge clk);
            w++;
        end
        check("t5_release_outputs_low", lowbad, 0);
        check("t5_restart_latency", w, 255);
        measure(-1, 2'd0, 8'd0);
        check("t5_after_commit_ch0_low", hi[0], 0);
        check("t5_after_commit_ch2_low", hi[2], 0);

        // Out-of-range channel writes on the 5-channel instance (period 15 clks).
        wr_valid5 = 1'b1;
        wr_chan5  = 3'd4;
        wr_duty5  = 4'd7;
        @(negedge clk);
        wr_chan5  = 3'd0;
        wr_duty5  = 4'd3;
        @(negedge clk);
        wr_chan5  = 3'd5;
        wr_duty5  = 4'd15;
        @(negedge clk);
        wr_chan5  = 3'd7;
        @(negedge clk);
        wr_valid5 = 1'b0;
        w = 0;
        while (period_start5 !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("oor_ps_budget", 32'(w < 40), 1);
        for (int i = 0; i < 5; i++) hi5[i] = 0;
        w = 0;
        do begin
            for (int i = 0; i < 5; i++) hi5[i] += int'(pwm_out5[i]);
            w++;
            @(negedge clk);
        end while (period_start5 !== 1'b1 && w < 40);
        check("oor_period_len", w, 15);
        check("oor_ch0_high", hi5[0], 3);
        check("oor_ch1_high", hi5[1], 0);
        check("oor_ch2_high", hi5[2], 0);
        check("oor_ch3_high", hi5[3], 0);
        check("oor_ch4_high", hi5[4], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
